// File: rtl/alu_pkg.sv
// Shared ALU definitions: command codes, error bit positions and datapath widths.
package alu_pkg;

  localparam int OPERAND_W = 16;
  localparam int RESULT_W  = 32;

  typedef logic [3:0] cmd_t;

  localparam cmd_t CMD_NOP = 4'd0;
  localparam cmd_t CMD_ADD = 4'd1;
  localparam cmd_t CMD_SUB = 4'd2;
  localparam cmd_t CMD_MUL = 4'd3;
  localparam cmd_t CMD_DIV = 4'd4;
  localparam cmd_t CMD_MOD = 4'd5;

  localparam int ERR_OVF = 0;
  localparam int ERR_DBZ = 1;

  function automatic logic cmd_is_legal(input cmd_t cmd);
    return (cmd >= CMD_ADD) && (cmd <= CMD_MOD);
  endfunction

endpackage

// File: rtl/alu_sat_counter.sv
// 16-bit counter that increments on inc and sticks at all-ones.
module alu_sat_counter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc,
  output logic [15:0] count
);

  logic [15:0] count_q;
  logic [15:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) count_d = count_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/alu_cmd_issuer.sv
// Issues one request at a time to a combinational ALU and returns its result.
// Optional error counter enabled by defining ALU_CMD_ISSUER_ERRCNT_EN.
module alu_cmd_issuer
  import alu_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [OPERAND_W-1:0] req_a,
  input  logic [OPERAND_W-1:0] req_b,
  input  logic [3:0]           req_cmd,
  output logic [OPERAND_W-1:0] alu_a,
  output logic [OPERAND_W-1:0] alu_b,
  output logic [3:0]           alu_cmd,
  input  logic [RESULT_W-1:0]  alu_result,
  input  logic [1:0]           alu_error,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [RESULT_W-1:0]  rsp_result,
  output logic [1:0]           rsp_error,
  output logic                 busy,
  output logic [15:0]          err_count
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  logic [1:0]           state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [OPERAND_W-1:0] alu_a_q, alu_a_d;
  logic [OPERAND_W-1:0] alu_b_q, alu_b_d;
  logic [3:0]           alu_cmd_q, alu_cmd_d;
  logic [RESULT_W-1:0]  rsp_result_q, rsp_result_d;
  logic [1:0]           rsp_error_q, rsp_error_d;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_cmd_d    = alu_cmd_q;
    rsp_result_d = rsp_result_q;
    rsp_error_d  = rsp_error_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          if (cmd_is_legal(req_cmd)) begin
            alu_a_d   = req_a;
            alu_b_d   = req_b;
            alu_cmd_d = req_cmd;
            cnt_d     = '0;
            state_d   = ST_WAIT;
          end else begin
            // Illegal commands bypass the ALU and leave its inputs untouched.
            rsp_result_d          = '0;
            rsp_error_d           = '0;
            rsp_error_d[ERR_DBZ]  = 1'b1;
            rsp_error_d[ERR_OVF]  = 1'b1;
            state_d               = ST_RESP;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == SETTLE_LAST) begin
          rsp_result_d = alu_result;
          rsp_error_d  = alu_error;
          state_d      = ST_RESP;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_cmd_q    <= '0;
      rsp_result_q <= '0;
      rsp_error_q  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_cmd_q    <= alu_cmd_d;
      rsp_result_q <= rsp_result_d;
      rsp_error_q  <= rsp_error_d;
    end
  end

  // Gated by rst_n so no request is offered acceptance while reset is held.
  assign req_ready  = rst_n && (state_q == ST_IDLE);
  assign busy       = (state_q != ST_IDLE);
  assign rsp_valid  = (state_q == ST_RESP);
  assign rsp_result = rsp_result_q;
  assign rsp_error  = rsp_error_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_cmd    = alu_cmd_q;

`ifdef ALU_CMD_ISSUER_ERRCNT_EN
  logic err_inc;
  assign err_inc = (state_q == ST_RESP) && rsp_ready && (rsp_error_q != 2'b00);

  alu_sat_counter u_err_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (err_inc),
    .count (err_count)
  );
`else
  assign err_count = '0;
`endif

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Self-checking bench for alu_cmd_issuer with a behavioural ALU and reference model.
module tb_alu_cmd_issuer;

  localparam int SETTLE = 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready;
  logic [15:0] req_a, req_b;
  logic [3:0]  req_cmd;
  logic [15:0] alu_a, alu_b;
  logic [3:0]  alu_cmd;
  logic [31:0] alu_result;
  logic [1:0]  alu_error;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_result;
  logic [1:0]  rsp_error;
  logic        busy;
  logic [15:0] err_count;

  int total = 0;
  int bad   = 0;

  // Reference state: expected ALU inputs and error-response tally.
  logic [15:0] m_alu_a, m_alu_b;
  logic [3:0]  m_alu_cmd;
  int          m_errs;

  always #5 clk = ~clk;

  alu_cmd_issuer #(.SETTLE_CYCLES(SETTLE)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_cmd(req_cmd),
    .alu_a(alu_a), .alu_b(alu_b), .alu_cmd(alu_cmd),
    .alu_result(alu_result), .alu_error(alu_error),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_error(rsp_error),
    .busy(busy), .err_count(err_count)
  );

  function automatic logic [33:0] alu_model(input logic [15:0] a, input logic [15:0] b,
                                            input logic [3:0] cmd);
    int sa, sb, s;
    logic [31:0] r;
    logic [1:0]  e;
    sa = int'($signed(a));
    sb = int'($signed(b));
    r  = 32'd0;
    e  = 2'b00;
    case (cmd)
      4'd1: begin s = sa + sb; r = 32'(a) + 32'(b); e[0] = (s > 32767) || (s < -32768); end
      4'd2: begin s = sa - sb; r = 32'(a) - 32'(b); e[0] = (s > 32767) || (s < -32768); end
      4'd3: r = 32'(a) * 32'(b);
      4'd4: if (b == 16'd0) e = 2'b10; else r = 32'(a / b);
      4'd5: if (b == 16'd0) e = 2'b10; else r = 32'(a % b);
      default: ;
    endcase
    return {e, r};
  endfunction

  always_comb {alu_error, alu_result} = alu_model(alu_a, alu_b, alu_cmd);

  function automatic logic [33:0] expect_rsp(input logic [15:0] a, input logic [15:0] b,
                                             input logic [3:0] cmd);
    if (cmd == 4'd0 || cmd > 4'd5) return {2'b11, 32'd0};
    return alu_model(a, b, cmd);
  endfunction

  function automatic int expect_errcnt();
`ifdef ALU_CMD_ISSUER_ERRCNT_EN
    return (m_errs > 65535) ? 65535 : m_errs;
`else
    return 0;
`endif
  endfunction

  // Drives one request and collects its response after holding rsp_ready low for
  // stall extra cycles; tracks payload stability and idle outputs while stalled.
  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic [3:0] cmd,
                       input int stall, output int lat, output logic [31:0] res,
                       output logic [1:0] err, output bit stable, output bit bp_ok,
                       output bit timeout);
    int w;
    lat = 0; res = '0; err = '0; stable = 1'b1; bp_ok = 1'b1; timeout = 1'b0;
    w = 0;
    while (!req_ready && w < 50) begin @(posedge clk); #1; w++; end
    if (!req_ready) begin timeout = 1'b1; return; end
    req_valid = 1'b1; req_a = a; req_b = b; req_cmd = cmd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_a = 16'($urandom); req_b = 16'($urandom); req_cmd = 4'($urandom);
    if (cmd != 4'd0 && cmd <= 4'd5) begin m_alu_a = a; m_alu_b = b; m_alu_cmd = cmd; end
    lat = 1;
    while (!rsp_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    if (!rsp_valid) begin timeout = 1'b1; return; end
    res = rsp_result; err = rsp_error;
    if (req_ready !== 1'b0 || busy !== 1'b1) bp_ok = 1'b0;
    repeat (stall) begin
      @(posedge clk); #1;
      req_a = 16'($urandom); req_b = 16'($urandom); req_cmd = 4'($urandom);
      if (rsp_valid !== 1'b1 || rsp_result !== res || rsp_error !== err) stable = 1'b0;
      if (req_ready !== 1'b0 || busy !== 1'b1) bp_ok = 1'b0;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    if (err != 2'b00) m_errs++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({rsp_valid, rsp_result, rsp_error, alu_a, alu_b, alu_cmd, err_count, busy, req_ready} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got valid=%b res=%0d err=%b a=%0d b=%0d cmd=%0d cnt=%0d busy=%b rdy=%b, want all 0",
               rsp_valid, rsp_result, rsp_error, alu_a, alu_b, alu_cmd, err_count, busy, req_ready);
    end
    rst_n = 1'b1;
    #1;
    total++;
    if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_release_ready: got %b want 1", req_ready); end
    m_alu_a = '0; m_alu_b = '0; m_alu_cmd = '0; m_errs = 0;
  endtask

  task automatic test_basic_ops();
    logic [15:0] av [5] = '{16'd249, 16'd249, 16'd249, 16'd249, 16'd249};
    logic [31:0] ev [5] = '{32'd318, 32'd180, 32'd17181, 32'd3, 32'd42};
    int lat; logic [31:0] r; logic [1:0] e; bit st, bp, to;
    for (int i = 0; i < 5; i++) begin
      issue(av[i], 16'd69, 4'(i + 1), 0, lat, r, e, st, bp, to);
      total++;
      if (to || lat != 1 + SETTLE || r !== ev[i] || e !== 2'b00) begin
        bad++;
        $display("FAIL basic_op cmd=%0d: got lat=%0d res=%0d err=%b to=%b want lat=%0d res=%0d err=00",
                 i + 1, lat, r, e, to, 1 + SETTLE, ev[i]);
      end
    end
  endtask

  task automatic test_errors();
    int lat; logic [31:0] r; logic [1:0] e; bit st, bp, to;
    int base;
    base = m_errs;
    issue(16'd32000, 16'd8193, 4'd1, 0, lat, r, e, st, bp, to);
    total++;
    if (to || r !== 32'd40193 || e !== 2'b01) begin
      bad++; $display("FAIL overflow: got res=%0d err=%b to=%b want res=40193 err=01", r, e, to);
    end
    issue(16'd100, 16'd0, 4'd4, 0, lat, r, e, st, bp, to);
    total++;
    if (to || e !== 2'b10) begin
      bad++; $display("FAIL div_by_zero: got err=%b to=%b want 10", e, to);
    end
    total++;
    if (int'(err_count) != expect_errcnt() || m_errs - base != 2) begin
      bad++; $display("FAIL err_count: got %0d want %0d", err_count, expect_errcnt());
    end
  endtask

  task automatic test_illegal();
    logic [3:0] cmds [3] = '{4'd7, 4'd0, 4'd15};
    int lat; logic [31:0] r; logic [1:0] e; bit st, bp, to;
    logic [3:0] prev_cmd;
    for (int i = 0; i < 3; i++) begin
      prev_cmd = alu_cmd;
      issue(16'h1234, 16'h0042, cmds[i], 0, lat, r, e, st, bp, to);
      total++;
      if (to || lat != 1 || r !== 32'd0 || e !== 2'b11) begin
        bad++;
        $display("FAIL illegal cmd=%0d: got lat=%0d res=%0d err=%b to=%b want lat=1 res=0 err=11",
                 cmds[i], lat, r, e, to);
      end
      total++;
      if (alu_cmd !== prev_cmd || alu_a !== m_alu_a || alu_b !== m_alu_b) begin
        bad++;
        $display("FAIL illegal_alu_hold cmd=%0d: got alu_cmd=%0d a=%0d b=%0d want %0d %0d %0d",
                 cmds[i], alu_cmd, alu_a, alu_b, prev_cmd, m_alu_a, m_alu_b);
      end
    end
    total++;
    if (int'(err_count) != expect_errcnt()) begin
      bad++; $display("FAIL illegal_err_count: got %0d want %0d", err_count, expect_errcnt());
    end
  endtask

  task automatic test_backpressure();
    int lat; logic [31:0] r; logic [1:0] e; bit st, bp, to;
    issue(16'd1000, 16'd7, 4'd3, 4, lat, r, e, st, bp, to);
    total++;
    if (to || !st || r !== 32'd7000 || e !== 2'b00) begin
      bad++; $display("FAIL bp_payload: got res=%0d err=%b stable=%b to=%b want 7000 00 stable", r, e, st, to);
    end
    total++;
    if (!bp) begin bad++; $display("FAIL bp_ready_busy: got req_ready/busy wrong during stall, want 0/1"); end
    total++;
    if (busy !== 1'b0 || req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      bad++; $display("FAIL bp_release: got busy=%b rdy=%b valid=%b want 0 1 0", busy, req_ready, rsp_valid);
    end
  endtask

  task automatic test_random();
    int lat; logic [31:0] r; logic [1:0] e; bit st, bp, to;
    logic [15:0] a, b; logic [3:0] c; logic [33:0] x; int stall, el;
    for (int n = 0; n < 40; n++) begin
      a = 16'($urandom);
      b = ($urandom_range(0, 5) == 0) ? 16'd0 : 16'($urandom_range(0, 300));
      c = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'($urandom_range(1, 5));
      stall = $urandom_range(0, 3);
      x = expect_rsp(a, b, c);
      el = (c == 4'd0 || c > 4'd5) ? 1 : 1 + SETTLE;
      issue(a, b, c, stall, lat, r, e, st, bp, to);
      total++;
      if (to || lat != el || r !== x[31:0] || e !== x[33:32] || !st || !bp) begin
        bad++;
        $display("FAIL rand[%0d] a=%0d b=%0d cmd=%0d: got lat=%0d res=%0d err=%b st=%b bp=%b to=%b want lat=%0d res=%0d err=%b",
                 n, a, b, c, lat, r, e, st, bp, to, el, x[31:0], x[33:32]);
      end
      total++;
      if (alu_a !== m_alu_a || alu_b !== m_alu_b || alu_cmd !== m_alu_cmd ||
          int'(err_count) != expect_errcnt()) begin
        bad++;
        $display("FAIL rand_state[%0d]: got a=%0d b=%0d cmd=%0d cnt=%0d want %0d %0d %0d %0d",
                 n, alu_a, alu_b, alu_cmd, err_count, m_alu_a, m_alu_b, m_alu_cmd, expect_errcnt());
      end
    end
  endtask

  task automatic test_reset_mid_op();
    int w;
    bit seen;
    w = 0;
    while (!req_ready && w < 50) begin @(posedge clk); #1; w++; end
    req_valid = 1'b1; req_a = 16'd321; req_b = 16'd5; req_cmd = 4'd3;
    @(posedge clk); #1;
    req_valid = 1'b0;
    total++;
    if (busy !== 1'b1 || rsp_valid !== 1'b0) begin
      bad++; $display("FAIL mid_wait_state: got busy=%b valid=%b want 1 0", busy, rsp_valid);
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    total++;
    if ({rsp_valid, rsp_result, rsp_error, alu_a, alu_b, alu_cmd, err_count, busy, req_ready} !== '0) begin
      bad++;
      $display("FAIL mid_reset_outputs: got valid=%b res=%0d err=%b a=%0d b=%0d cmd=%0d cnt=%0d busy=%b rdy=%b, want all 0",
               rsp_valid, rsp_result, rsp_error, alu_a, alu_b, alu_cmd, err_count, busy, req_ready);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_alu_a = '0; m_alu_b = '0; m_alu_cmd = '0; m_errs = 0;
    #1;
    total++;
    if (req_ready !== 1'b1) begin bad++; $display("FAIL mid_reset_ready: got %b want 1", req_ready); end
    seen = 1'b0;
    repeat (6) begin @(posedge clk); #1; if (rsp_valid !== 1'b0) seen = 1'b1; end
    total++;
    if (seen) begin bad++; $display("FAIL mid_reset_no_rsp: got rsp_valid=1 want no response"); end
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
    req_a = '0; req_b = '0; req_cmd = '0;
    m_alu_a = '0; m_alu_b = '0; m_alu_cmd = '0; m_errs = 0;
    test_reset();
    test_basic_ops();
    test_errors();
    test_illegal();
    test_backpressure();
    test_random();
    test_reset_mid_op();
    test_basic_ops();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_cmd_issuer.md
ALU_CMD_ISSUER -- requirements
Module: alu_cmd_issuer

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 1: cycles the ALU inputs are held stable before the result is captured, legal range 1..15.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-004 SHALL have port req_valid, input, 1 bit: a request is offered.
REQ-005 SHALL have port req_ready, output, 1 bit: the issuer accepts a request this cycle.
REQ-006 SHALL have ports req_a, input, 16 bits, and req_b, input, 16 bits: the operands.
REQ-007 SHALL have port req_cmd, input, 4 bits: the operation, encoded 1=add, 2=sub, 3=mul, 4=div, 5=mod.
REQ-008 SHALL have ports alu_a, output, 16 bits; alu_b, output, 16 bits; and alu_cmd, output, 4 bits: these drive the combinational ALU.
REQ-009 SHALL have ports alu_result, input, 32 bits, and alu_error, input, 2 bits: the ALU returns these, with bit1 = divide-by-zero and bit0 = overflow.
REQ-010 SHALL have port rsp_valid, output, 1 bit: a response is presented.
REQ-011 SHALL have port rsp_ready, input, 1 bit: the consumer accepts the response.
REQ-012 SHALL have ports rsp_result, output, 32 bits, and rsp_error, output, 2 bits: the response payload.
REQ-013 SHALL have port busy, output, 1 bit: high whenever state is not IDLE.
REQ-014 SHALL have port err_count, output, 16 bits: the count of error responses (see REQ-027).

Function
REQ-015 SHALL implement FSM states IDLE, WAIT and RESP.
REQ-016 SHALL drive req_ready high only in IDLE; a handshake is req_valid && req_ready.
REQ-017 On a handshake at cycle T with a legal cmd, SHALL register alu_a/alu_b/alu_cmd from the request and enter WAIT at T+1.
REQ-018 WAIT SHALL count SETTLE_CYCLES cycles, capture alu_result/alu_error into rsp_result/rsp_error on the last WAIT edge, and enter RESP, so rsp_valid first rises at T+1+SETTLE_CYCLES.
REQ-019 On a handshake with an illegal cmd (0, or 6..15), SHALL skip WAIT, leave the alu_* outputs unchanged, and enter RESP at T+1 with rsp_result=0 and rsp_error=2'b11.
REQ-020 In RESP, rsp_valid SHALL stay high and rsp_result/rsp_error SHALL stay stable until rsp_ready is sampled high; the state then returns to IDLE on that edge.
REQ-021 Requests SHALL NOT overlap: a new request is accepted no earlier than the cycle after the response handshake.
REQ-022 alu_a/alu_b/alu_cmd SHALL hold their values from the end of WAIT until the next accepted legal request; after reset alu_cmd=0, which selects the ALU ground channel.
REQ-023 req_a, req_b and req_cmd SHALL be ignored outside a handshake cycle.

Reset
REQ-024 While rst_n is low at a clock edge, SHALL set state=IDLE, rsp_valid=0, rsp_result=0, rsp_error=0, alu_a=0, alu_b=0, alu_cmd=0, err_count=0, and busy=0.
REQ-025 A reset in WAIT or RESP SHALL discard the in-flight operation with no response; req_ready SHALL be 0 while rst_n is low and SHALL be 1 on the first cycle after rst_n is high.

Configuration
REQ-026 The feature is controlled by macro ALU_CMD_ISSUER_ERRCNT_EN.
REQ-027 With ALU_CMD_ISSUER_ERRCNT_EN defined, err_count SHALL increment by 1 at each response handshake where rsp_error != 0, saturating at 16'hFFFF.
REQ-028 Without ALU_CMD_ISSUER_ERRCNT_EN, err_count SHALL be tied to 0 with no counter logic, and the port list SHALL be unchanged.

Structure
REQ-029 Shared package alu_pkg SHALL hold the command constants (CMD_NOP=0, CMD_ADD=1, CMD_SUB=2, CMD_MUL=3, CMD_DIV=4, CMD_MOD=5), the error bit indices (ERR_OVF=0, ERR_DBZ=1), the operand width 16 and the result width 32.
REQ-030 FSM state encoding SHALL be local to alu_cmd_issuer.
REQ-031 One sub-module, alu_sat_counter, SHALL implement the 16-bit saturating counter, instantiated only under the macro.

Verification
REQ-032 A=249, B=69, cmd=1, SETTLE_CYCLES=1 -> rsp_result=318, rsp_error=2'b00, rsp_valid at T+2.
REQ-033 A=249, B=69, cmds 2/3/4/5 in sequence -> results 180 / 17181 / 3 / 42, each with rsp_error=2'b00.
REQ-034 A=32000, B=8193, cmd=1 -> rsp_result=40193, rsp_error=2'b01; then A=100, B=0, cmd=4 -> rsp_error=2'b10, err_count=2 with the macro and 0 without it.
REQ-035 cmd=7 -> rsp_valid at T+1, rsp_result=0, rsp_error=2'b11, alu_cmd unchanged.
REQ-036 Backpressure: rsp_ready held low for 5 cycles -> payload stable, req_ready=0 and busy=1 throughout; IDLE the cycle after rsp_ready=1.
REQ-037 Reset mid-op: rst_n low during WAIT -> no rsp_valid ever for that request, all outputs 0 the next cycle, and req_ready=1 on the first cycle after rst_n is high.
